// File: rtl/glyph_column_feeder.sv
// glyph_column_feeder
//   Walks a message of MSG_LEN consecutive glyphs in a glyph ROM, starting
//   at START_ADDR. Each 8x8 glyph is fetched, captured, and emitted as eight
//   pixel columns followed by GAP_COLS blank columns. Successive columns are
//   spaced by STEP_DIV enabled clock cycles, and each column is offered on a
//   valid/ready beat.
//
// Ports
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   en         : advance enable for the step counter
//   char_addr  : glyph ROM address (registered)
//   glyph      : ROM data, one cycle after char_addr; bits 63:56 = top row,
//                bit 7 of a row byte = leftmost pixel
//   col_data   : column pixels, bit r = row r
//   col_valid  : column beat valid
//   col_ready  : downstream accepts the beat
//   last_col   : marks the final column (gap included) of the last glyph
module glyph_column_feeder #(
   parameter int MSG_LEN    = 16,
   parameter int START_ADDR = 0,
   parameter int GAP_COLS   = 1,
   parameter int STEP_DIV   = 5_000_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   output logic [5:0]  char_addr,
   input  logic [63:0] glyph,
   output logic [7:0]  col_data,
   output logic        col_valid,
   input  logic        col_ready,
   output logic        last_col
);

   localparam int CNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(STEP_DIV - 1);
   localparam logic [3:0]       COL_LAST   = 4'(7 + GAP_COLS);
   localparam logic [5:0]       ADDR_FIRST = 6'(START_ADDR);
   localparam logic [5:0]       ADDR_LAST  = 6'(START_ADDR + MSG_LEN - 1);

   if ((MSG_LEN < 1) || (MSG_LEN > 64) || (START_ADDR < 0) ||
       (START_ADDR + MSG_LEN > 64) || (GAP_COLS < 0) || (GAP_COLS > 7) ||
       (STEP_DIV < 1)) begin : g_param_check
      $error("glyph_column_feeder: illegal parameter combination");
   end

   typedef enum logic [1:0] {S_FETCH, S_LOAD, S_WAIT, S_PRESENT} state_t;

   state_t           state_q;
   logic [5:0]       addr_q;
   logic [63:0]      glyph_q;
   logic [3:0]       col_idx_q;
   logic [CNT_W-1:0] cnt_q;
   logic [7:0]       data_q;
   logic             valid_q;
   logic             last_q;

   logic [7:0]       col_d;
   logic             last_d;

   // Pixel (row r, column c) lives at bit (7-r)*8 + (7-c), which is simply
   // the 6-bit concatenation {~r, ~c}. Columns 8 and up are blank gap.
   function automatic logic [7:0] column_of(input logic [63:0] g,
                                            input logic [3:0]  idx);
      logic [7:0] c;
      logic [2:0] rr;
      c = '0;
      if (idx < 4'd8) begin
         for (int r = 0; r < 8; r++) begin
            rr    = 3'(r);
            c[rr] = g[{~rr, ~idx[2:0]}];
         end
      end
      return c;
   endfunction

   always_comb begin
      col_d  = column_of(glyph_q, col_idx_q);
      last_d = (col_idx_q == COL_LAST) && (addr_q == ADDR_LAST);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_FETCH;
         addr_q    <= ADDR_FIRST;
         glyph_q   <= '0;
         col_idx_q <= '0;
         cnt_q     <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         last_q    <= 1'b0;
      end else begin
         case (state_q)
            // ROM sees char_addr this cycle; data arrives during LOAD.
            S_FETCH: state_q <= S_LOAD;
            S_LOAD: begin
               glyph_q   <= glyph;
               col_idx_q <= '0;
               state_q   <= S_WAIT;
            end
            S_WAIT: begin
               if (en) begin
                  if (cnt_q == CNT_LAST) begin
                     cnt_q   <= '0;
                     data_q  <= col_d;
                     last_q  <= last_d;
                     valid_q <= 1'b1;
                     state_q <= S_PRESENT;
                  end else begin
                     cnt_q <= cnt_q + CNT_W'(1);
                  end
               end
            end
            // Beat is held until accepted; en has no effect here.
            S_PRESENT: begin
               if (col_ready) begin
                  valid_q <= 1'b0;
                  last_q  <= 1'b0;
                  if (col_idx_q == COL_LAST) begin
                     addr_q  <= (addr_q == ADDR_LAST) ? ADDR_FIRST : addr_q + 6'd1;
                     state_q <= S_FETCH;
                  end else begin
                     col_idx_q <= col_idx_q + 4'd1;
                     state_q   <= S_WAIT;
                  end
               end
            end
            default: state_q <= S_FETCH;
         endcase
      end
   end

   assign char_addr = addr_q;
   assign col_data  = data_q;
   assign col_valid = valid_q;
   assign last_col  = last_q;

endmodule

// File: tb/tb_glyph_column_feeder.sv
// Bench for glyph_column_feeder: two instances with different parameter
// sets, a behavioural ROM, a beat-order reference model per instance, a
// vector table for the first glyph, and directed multi-cycle sequences.
module tb_glyph_column_feeder;

   localparam int A_SD = 4, A_GAP = 1, A_LEN = 5, A_START = 0;
   localparam int B_SD = 2, B_GAP = 0, B_LEN = 2, B_START = 10;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_a, en_a, ready_a, valid_a, last_a;
   logic [5:0]  addr_a;
   logic [63:0] glyph_a;
   logic [7:0]  data_a;
   logic        rst_b, en_b, ready_b, valid_b, last_b;
   logic [5:0]  addr_b;
   logic [63:0] glyph_b;
   logic [7:0]  data_b;

   logic [63:0] rom [64];

   int checks = 0;
   int failures = 0;
   bit done_a = 0, done_b = 0;

   glyph_column_feeder #(.MSG_LEN(A_LEN), .START_ADDR(A_START),
                         .GAP_COLS(A_GAP), .STEP_DIV(A_SD)) u_a (
      .clk(clk), .rst(rst_a), .en(en_a), .char_addr(addr_a), .glyph(glyph_a),
      .col_data(data_a), .col_valid(valid_a), .col_ready(ready_a),
      .last_col(last_a));

   glyph_column_feeder #(.MSG_LEN(B_LEN), .START_ADDR(B_START),
                         .GAP_COLS(B_GAP), .STEP_DIV(B_SD)) u_b (
      .clk(clk), .rst(rst_b), .en(en_b), .char_addr(addr_b), .glyph(glyph_b),
      .col_data(data_b), .col_valid(valid_b), .col_ready(ready_b),
      .last_col(last_b));

   // Synchronous ROM: data one clock after the address is sampled.
   always @(posedge clk) begin
      glyph_a <= rom[addr_a];
      glyph_b <= rom[addr_b];
   end

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Column c of a glyph, read out of its row bytes (top row first).
   function automatic logic [7:0] ref_col(input logic [63:0] g, input int c);
      logic [7:0] rows [8];
      logic [7:0] res;
      res = 8'h00;
      for (int r = 0; r < 8; r++) rows[r] = g[63-8*r -: 8];
      if (c < 8)
         for (int r = 0; r < 8; r++) res[r] = rows[r][7-c];
      return res;
   endfunction

   // Reference model state: glyph offset / column of the next expected beat.
   int eg_a = 0, ec_a = 0, hs_a = 0;
   int eg_b = 0, ec_b = 0, hs_b = 0;
   logic pr_rst_a = 0, pr_val_a = 0, pr_rdy_a = 0, pr_last_a = 0;
   logic pr_rst_b = 0, pr_val_b = 0, pr_rdy_b = 0, pr_last_b = 0;
   logic [7:0] pr_data_a = 0, pr_data_b = 0;

   always @(negedge clk) begin
      if (pr_rst_a) begin
         check("A reset state", {valid_a, last_a, data_a, addr_a},
               {1'b0, 1'b0, 8'h00, 6'(A_START)});
         eg_a <= 0;
         ec_a <= 0;
      end else if (pr_val_a && !pr_rdy_a) begin
         check("A hold", {valid_a, last_a, data_a}, {1'b1, pr_last_a, pr_data_a});
      end
      if (valid_a && ready_a && !rst_a && !pr_rst_a) begin
         check("A beat addr", addr_a, 6'(A_START + eg_a));
         check("A beat data", data_a, ref_col(rom[A_START + eg_a], ec_a));
         check("A beat last", last_a, (ec_a == 7 + A_GAP) && (eg_a == A_LEN - 1));
         hs_a <= hs_a + 1;
         ec_a <= (ec_a == 7 + A_GAP) ? 0 : ec_a + 1;
         if (ec_a == 7 + A_GAP) eg_a <= (eg_a + 1) % A_LEN;
      end
      pr_rst_a  <= rst_a;
      pr_val_a  <= valid_a;
      pr_rdy_a  <= ready_a;
      pr_last_a <= last_a;
      pr_data_a <= data_a;
   end

   always @(negedge clk) begin
      if (pr_rst_b) begin
         check("B reset state", {valid_b, last_b, data_b, addr_b},
               {1'b0, 1'b0, 8'h00, 6'(B_START)});
         eg_b <= 0;
         ec_b <= 0;
      end else if (pr_val_b && !pr_rdy_b) begin
         check("B hold", {valid_b, last_b, data_b}, {1'b1, pr_last_b, pr_data_b});
      end
      if (valid_b && ready_b && !rst_b && !pr_rst_b) begin
         check("B beat addr", addr_b, 6'(B_START + eg_b));
         check("B beat data", data_b, ref_col(rom[B_START + eg_b], ec_b));
         check("B beat last", last_b, (ec_b == 7 + B_GAP) && (eg_b == B_LEN - 1));
         hs_b <= hs_b + 1;
         ec_b <= (ec_b == 7 + B_GAP) ? 0 : ec_b + 1;
         if (ec_b == 7 + B_GAP) eg_b <= (eg_b + 1) % B_LEN;
      end
      pr_rst_b  <= rst_b;
      pr_val_b  <= valid_b;
      pr_rdy_b  <= ready_b;
      pr_last_b <= last_b;
      pr_data_b <= data_b;
   end

   // Counts rising edges until col_valid is seen high, bounded by limit.
   task automatic wait_valid(input int inst, input int limit, output int n);
      logic v;
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
         v = (inst == 0) ? valid_a : valid_b;
      end while (!v && n < limit);
      if (!v) check("wait for col_valid", v, 1'b1);
   endtask

   typedef struct {
      logic [7:0] data;
      logic [5:0] addr;
      logic       last;
      int         period;
   } vec_t;

   initial begin : seq_a
      vec_t tbl [10];
      logic [7:0] first_cols [9];
      int n, n2, k;

      for (int i = 0; i < 64; i++) rom[i] = {$urandom, $urandom};
      rom[0] = 64'h3c66663e06663c00;

      // Columns of rom[0] read from its row bytes, then one gap column.
      first_cols = '{8'h00, 8'h26, 8'h6f, 8'h49, 8'h49, 8'h7f, 8'h3e, 8'h00, 8'h00};
      for (int i = 0; i < 9; i++)
         tbl[i] = '{first_cols[i], 6'd0, 1'b0, (i == 0) ? A_SD + 2 : A_SD + 1};
      tbl[9] = '{ref_col(rom[1], 0), 6'd1, 1'b0, A_SD + 3};

      rst_a = 1; en_a = 1; ready_a = 1;
      repeat (3) @(posedge clk);
      #1 rst_a = 0;

      for (int i = 0; i < 10; i++) begin
         wait_valid(0, 100, n);
         check($sformatf("A vec%0d period", i), n, tbl[i].period);
         check($sformatf("A vec%0d data", i), data_a, tbl[i].data);
         check($sformatf("A vec%0d addr", i), addr_a, tbl[i].addr);
         check($sformatf("A vec%0d last", i), last_a, tbl[i].last);
      end

      // en low for three WAIT cycles stretches the period by three.
      @(posedge clk); #1;
      en_a = 0;
      repeat (3) begin @(posedge clk); #1; end
      en_a = 1;
      wait_valid(0, 100, n2);
      check("A en-gap period", 4 + n2, A_SD + 1 + 3);

      // en low while presenting must not drop the beat.
      en_a = 0; ready_a = 0;
      repeat (4) begin
         @(posedge clk); #1;
         check("A valid with en low", valid_a, 1'b1);
      end
      en_a = 1; ready_a = 1;

      repeat (1500) begin
         @(posedge clk); #1;
         ready_a = 1'($urandom_range(0, 1));
         en_a    = ($urandom_range(0, 3) != 0);
         rst_a   = ($urandom_range(0, 299) == 0);
      end
      rst_a = 0;

      // Reset in the middle of column 5 of glyph 3.
      ready_a = 1; en_a = 1; rst_a = 1;
      @(posedge clk); #1 rst_a = 0;
      k = 0;
      while (!(valid_a && eg_a == 3 && ec_a == 5) && k < 3000) begin
         @(posedge clk); #1;
         k++;
      end
      ready_a = 0;
      check("A reached glyph3 col5", valid_a && eg_a == 3 && ec_a == 5, 1'b1);
      check("A glyph3 addr", addr_a, 6'(A_START + 3));
      rst_a = 1;
      @(posedge clk); #1 rst_a = 0;
      check("A valid after mid-beat reset", valid_a, 1'b0);
      check("A addr after mid-beat reset", addr_a, 6'(A_START));
      ready_a = 1;
      wait_valid(0, 100, n);
      check("A first beat latency", n, A_SD + 2);
      check("A first beat data", data_a, ref_col(rom[A_START], 0));
      check("A first beat addr", addr_a, 6'(A_START));
      repeat (4) @(posedge clk);
      done_a = 1;
   end

   initial begin : seq_b
      int n, hs0, k;
      logic [7:0] d0;

      rst_b = 1; en_b = 1; ready_b = 0;
      repeat (3) @(posedge clk);
      #1 rst_b = 0;
      wait_valid(1, 100, n);
      check("B first valid latency", n, B_SD + 2);

      // Five stalled cycles, then exactly one accepted beat.
      d0  = data_b;
      hs0 = hs_b;
      repeat (5) begin
         @(posedge clk); #1;
         check("B stall", {valid_b, data_b}, {1'b1, d0});
      end
      ready_b = 1;
      @(posedge clk); #1;
      ready_b = 0;
      check("B valid after accept", valid_b, 1'b0);
      check("B beats accepted", hs_b - hs0, 1);

      // Run to the last column of the message, then across the wrap.
      ready_b = 1;
      k = 0;
      while (!(valid_b && last_b) && k < 500) begin
         @(posedge clk); #1;
         k++;
      end
      check("B last_col seen", valid_b && last_b, 1'b1);
      check("B last_col addr", addr_b, 6'(B_START + 1));
      wait_valid(1, 100, n);
      check("B wrap addr", addr_b, 6'(B_START));
      check("B wrap period", n, B_SD + 3);
      check("B wrap last", last_b, 1'b0);

      repeat (800) begin
         @(posedge clk); #1;
         ready_b = 1'($urandom_range(0, 1));
         en_b    = ($urandom_range(0, 2) != 0);
      end
      ready_b = 1;
      repeat (4) @(posedge clk);
      done_b = 1;
   end

   initial begin : finisher
      fork
         wait (done_a && done_b);
         #300000;
      join_any
      if (!(done_a && done_b)) check("global time limit", done_a && done_b, 1'b1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
